axis_measure_ctrl_master: RTL and testbench

AXI4-Lite master that drives the control/status register file of the AXI-Stream measurement block from on-chip logic instead of the host. It accepts simple commands (stop, start, clear, snapshot). For control commands it writes the CONTROL register. For a snapshot it reads the six counter words and presents them as three coherent 64-bit values. It sits on the measurer's `s_axi_control` port, so self-test and on-chip benchmarking can run without a host driver.

---
 rtl/axis_measure_ctrl_pkg.sv | 45 ++++
 rtl/axis_measure_ctrl_master_timer.sv | 27 ++
 rtl/axis_measure_ctrl_master.sv | 186 ++++++++++++++++++
 tb/tb_axis_measure_ctrl_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_measure_ctrl_pkg.sv
// Shared definitions for the on-chip AXI-Lite master that drives the
// measurement block's control/status register file.
package axis_measure_ctrl_pkg;

  localparam int unsigned REG_CONTROL    = 16;
  localparam int unsigned REG_ASSERTIONS = 20;
  localparam int unsigned REG_CYCLES     = 28;
  localparam int unsigned REG_LATENCY    = 36;
  localparam int unsigned REG_DATA_WIDTH = 44;
  localparam int unsigned REG_LAST_FRAME = 48;

  localparam logic [31:0] CTRL_STOP  = 32'd0;
  localparam logic [31:0] CTRL_START = 32'd1;
  localparam logic [31:0] CTRL_CLEAR = 32'd2;

  localparam logic [1:0]  AXI_OKAY   = 2'b00;
  localparam int unsigned SNAP_WORDS = 6;

  typedef enum logic [1:0] {
    OP_STOP     = 2'd0,
    OP_START    = 2'd1,
    OP_CLEAR    = 2'd2,
    OP_SNAPSHOT = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_FINISH
  } state_e;

  function automatic logic [31:0] ctrl_code(input cmd_op_e op);
    logic [31:0] code;
    case (op)
      OP_START: code = CTRL_START;
      OP_CLEAR: code = CTRL_CLEAR;
      default:  code = CTRL_STOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/axis_measure_ctrl_master_timer.sv
// Per-state handshake timeout: counts while a handshake state is active,
// restarts on every state change. TIMEOUT_CYCLES = 0 disables expiry.
module axil_handshake_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic restart,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || restart) begin
      count <= '0;
    end else if (active && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/axis_measure_ctrl_master.sv
// AXI4-Lite master issuing CONTROL writes and coherent 6-word counter
// snapshots to the measurement block's register file.
module axis_measure_ctrl_master
  import axis_measure_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  output logic                    m_axi_control_awvalid,
  input  logic                    m_axi_control_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_control_awaddr,
  output logic                    m_axi_control_wvalid,
  input  logic                    m_axi_control_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_control_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_control_wstrb,
  input  logic                    m_axi_control_bvalid,
  output logic                    m_axi_control_bready,
  input  logic [1:0]              m_axi_control_bresp,
  output logic                    m_axi_control_arvalid,
  input  logic                    m_axi_control_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_control_araddr,
  input  logic                    m_axi_control_rvalid,
  output logic                    m_axi_control_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_control_rdata,
  input  logic [1:0]              m_axi_control_rresp,
  output logic [63:0]             snap_assertions,
  output logic [63:0]             snap_cycles,
  output logic [63:0]             snap_latency,
  output logic                    done,
  output logic [1:0]              err
);

  localparam logic [2:0] LAST_IDX = 3'(SNAP_WORDS - 1);

  state_e                state, next_state;
  cmd_op_e               op_q;
  logic [2:0]            idx;
  logic                  aw_done, w_done;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] shadow [SNAP_WORDS-1];
  logic                  expired, timer_active;
  logic                  aw_hs, w_hs, b_hs, r_hs;

  axil_handshake_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .restart(next_state != state),
    .active (timer_active),
    .expired(expired)
  );

  // AXI outputs depend only on registered state, never on inputs.
  always_comb begin
    next_state            = state;
    timer_active          = 1'b0;
    m_axi_control_awvalid = 1'b0;
    m_axi_control_awaddr  = '0;
    m_axi_control_wvalid  = 1'b0;
    m_axi_control_wdata   = '0;
    m_axi_control_wstrb   = '0;
    m_axi_control_bready  = 1'b0;
    m_axi_control_arvalid = 1'b0;
    m_axi_control_araddr  = '0;
    m_axi_control_rready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          next_state = (cmd_op_e'(cmd_op) == OP_SNAPSHOT) ? ST_RD_ADDR : ST_WR;
        end
      end
      ST_WR: begin
        timer_active          = 1'b1;
        m_axi_control_awaddr  = BASE_ADDR + ADDR_WIDTH'(REG_CONTROL);
        m_axi_control_wdata   = DATA_WIDTH'(ctrl_code(op_q));
        m_axi_control_wstrb   = '1;
        m_axi_control_awvalid = !aw_done && !expired;
        m_axi_control_wvalid  = !w_done && !expired;
        m_axi_control_bready  = !expired;
        if (expired) begin
          next_state = ST_FINISH;
        end else if ((aw_done || (m_axi_control_awvalid && m_axi_control_awready)) &&
                     (w_done  || (m_axi_control_wvalid  && m_axi_control_wready))) begin
          next_state = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        timer_active         = 1'b1;
        m_axi_control_bready = !expired;
        if (expired || m_axi_control_bvalid) next_state = ST_FINISH;
      end
      ST_RD_ADDR: begin
        timer_active          = 1'b1;
        m_axi_control_arvalid = !expired;
        m_axi_control_araddr  = BASE_ADDR + ADDR_WIDTH'(REG_ASSERTIONS) + ADDR_WIDTH'({idx, 2'b00});
        if (expired) begin
          next_state = ST_FINISH;
        end else if (m_axi_control_arready) begin
          next_state = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        timer_active         = 1'b1;
        m_axi_control_rready = !expired;
        if (expired) begin
          next_state = ST_FINISH;
        end else if (m_axi_control_rvalid) begin
          next_state = (idx == LAST_IDX) ? ST_FINISH : ST_RD_ADDR;
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign aw_hs = m_axi_control_awvalid && m_axi_control_awready;
  assign w_hs  = m_axi_control_wvalid  && m_axi_control_wready;
  assign b_hs  = m_axi_control_bvalid  && m_axi_control_bready;
  assign r_hs  = m_axi_control_rvalid  && m_axi_control_rready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state           <= ST_IDLE;
      op_q            <= OP_STOP;
      idx             <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      err_q           <= '0;
      snap_assertions <= '0;
      snap_cycles     <= '0;
      snap_latency    <= '0;
      for (int unsigned i = 0; i < SNAP_WORDS - 1; i++) shadow[i] <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op_e'(cmd_op);
            idx     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= '0;
            for (int unsigned i = 0; i < SNAP_WORDS - 1; i++) shadow[i] <= '0;
          end
        end
        ST_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        ST_WR_RESP: begin
          if (b_hs && (m_axi_control_bresp != AXI_OKAY)) err_q[0] <= 1'b1;
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            if (m_axi_control_rresp != AXI_OKAY) err_q[0] <= 1'b1;
            // Last word bypasses the shadow so all three outputs load together
            // on the edge into FINISH.
            if (idx == LAST_IDX) begin
              snap_assertions <= {shadow[1], shadow[0]};
              snap_cycles     <= {shadow[3], shadow[2]};
              snap_latency    <= {m_axi_control_rdata, shadow[4]};
            end else begin
              shadow[idx] <= m_axi_control_rdata;
              idx         <= idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
      if (expired) err_q[1] <= 1'b1;
    end
  end

  assign cmd_ready = (state == ST_IDLE) && !ap_rst;
  assign done      = (state == ST_FINISH);
  assign err       = done ? err_q : '0;

endmodule

// File: tb/tb_axis_measure_ctrl_master.sv
// Bench for axis_measure_ctrl_master: behavioural AXI-Lite slave with
// programmable stalls/errors, command scoreboard and done-time monitor.
module tb_axis_measure_ctrl_master;

  localparam int unsigned AW   = 16;
  localparam logic [15:0] BASE = 16'h0400;
  localparam int unsigned TO   = 8;

  logic        ap_clk, ap_rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp, err;
  logic [63:0] snap_assertions, snap_cycles, snap_latency;
  logic        done;

  axis_measure_ctrl_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .m_axi_control_awvalid(awvalid), .m_axi_control_awready(awready), .m_axi_control_awaddr(awaddr),
    .m_axi_control_wvalid(wvalid), .m_axi_control_wready(wready), .m_axi_control_wdata(wdata),
    .m_axi_control_wstrb(wstrb),
    .m_axi_control_bvalid(bvalid), .m_axi_control_bready(bready), .m_axi_control_bresp(bresp),
    .m_axi_control_arvalid(arvalid), .m_axi_control_arready(arready), .m_axi_control_araddr(araddr),
    .m_axi_control_rvalid(rvalid), .m_axi_control_rready(rready), .m_axi_control_rdata(rdata),
    .m_axi_control_rresp(rresp),
    .snap_assertions(snap_assertions), .snap_cycles(snap_cycles), .snap_latency(snap_latency),
    .done(done), .err(err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int unsigned checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave register file and knobs ----------------
  logic [31:0] regs [16];
  int unsigned k_aw_dly, k_w_dly, k_b_dly, k_ar_dly, k_r_dly;
  bit          k_ar_hang;
  logic [1:0]  k_bresp;
  int          k_rerr_word;

  bit          aw_got, w_got, b_pend, r_pend;
  logic [15:0] aw_addr_s, r_addr_s;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          rd_count, wr_count;

  function automatic int reg_index(input logic [15:0] addr);
    logic [15:0] off;
    off = addr - BASE;
    if (off[1:0] != 2'b00 || off >= 16'd64) return -1;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] rd_word(input logic [15:0] addr);
    int i;
    i = reg_index(addr);
    return (i < 0) ? 32'hBAD0_0000 : regs[i];
  endfunction

  always @(posedge ap_clk) begin : slave
    int i;
    if (ap_rst) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      rd_count = 0;
      #2;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    end else begin
      if (rvalid && rready) begin r_pend = 0; rd_count++; end
      else if (r_pend) r_cnt++;
      if (arvalid && arready) begin r_pend = 1; r_addr_s = araddr; r_cnt = 0; ar_cnt = 0; end
      else if (arvalid) ar_cnt++;
      if (bvalid && bready) b_pend = 0;
      else if (b_pend) b_cnt++;
      if (awvalid && awready) begin aw_got = 1; aw_addr_s = awaddr; aw_cnt = 0; end
      else if (awvalid) aw_cnt++;
      if (wvalid && wready) begin w_got = 1; w_data_s = wdata; w_strb_s = wstrb; w_cnt = 0; end
      else if (wvalid) w_cnt++;
      if (aw_got && w_got) begin
        i = reg_index(aw_addr_s);
        if (i >= 0 && w_strb_s == 4'hF) regs[i] = w_data_s;
        wr_count++;
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
      end
      #2;
      awready = !aw_got && (aw_cnt >= k_aw_dly);
      wready  = !w_got && (w_cnt >= k_w_dly);
      bvalid  = b_pend && (b_cnt >= k_b_dly);
      bresp   = bvalid ? k_bresp : 2'b00;
      arready = !k_ar_hang && !r_pend && (ar_cnt >= k_ar_dly);
      rvalid  = r_pend && (r_cnt >= k_r_dly);
      rdata   = rvalid ? rd_word(r_addr_s) : 32'h0;
      rresp   = (rvalid && rd_count == k_rerr_word) ? 2'b10 : 2'b00;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          op;
    logic [1:0]  err;
    int unsigned lat;
    logic [63:0] a, c, l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] cnt_a, cnt_c, cnt_l;
  logic [63:0] snap_a = '0, snap_c = '0, snap_l = '0;
  int unsigned cyc = 0, acc_cyc = 0;

  always @(posedge ap_clk) begin
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    cyc++;
  end

  always @(negedge ap_clk) begin : monitor
    if (ap_rst) begin
      snap_a = '0; snap_c = '0; snap_l = '0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no command pending at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          check("err", 64'(err), 64'(mon_e.err));
          if (mon_e.lat != 0) check("done_latency", 64'(cyc - acc_cyc), 64'(mon_e.lat));
          if (mon_e.op != 3) begin
            check("write_count", 64'(wr_count), 64'd1);
            check("control_reg", 64'(regs[4]), 64'(mon_e.op));
          end else if (!mon_e.err[1]) begin
            snap_a = mon_e.a; snap_c = mon_e.c; snap_l = mon_e.l;
          end
        end
      end
      check("snap_assertions", snap_assertions, snap_a);
      check("snap_cycles", snap_cycles, snap_c);
      check("snap_latency", snap_latency, snap_l);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_counters(input logic [63:0] a, input logic [63:0] c, input logic [63:0] l);
    cnt_a = a; cnt_c = c; cnt_l = l;
    regs[5] = a[31:0]; regs[6]  = a[63:32];
    regs[7] = c[31:0]; regs[8]  = c[63:32];
    regs[9] = l[31:0]; regs[10] = l[63:32];
  endtask

  task automatic issue(input int op, input int unsigned aw_d, input int unsigned w_d,
                       input int unsigned b_d, input int unsigned ar_d, input int unsigned r_d,
                       input bit hang, input logic [1:0] br, input int rerr,
                       input int unsigned lat, input bit wait_done, output int unsigned arv_cycles);
    exp_t        e;
    int unsigned n;
    arv_cycles = 0;
    n = 0;
    @(negedge ap_clk);
    while (!cmd_ready && n < 100) begin @(negedge ap_clk); n++; end
    k_aw_dly = aw_d; k_w_dly = w_d; k_b_dly = b_d; k_ar_dly = ar_d; k_r_dly = r_d;
    k_ar_hang = hang; k_bresp = br; k_rerr_word = rerr;
    wr_count = 0; rd_count = 0;
    if (op != 3) regs[4] = 32'hDEAD_BEEF;
    e.op  = op;
    e.lat = lat;
    e.a = cnt_a; e.c = cnt_c; e.l = cnt_l;
    if (hang)         e.err = 2'b10;
    else if (op == 3) e.err = {1'b0, rerr >= 0};
    else              e.err = {1'b0, br != 2'b00};
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    @(posedge ap_clk);
    #1 cmd_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (sb.size() != 0 && n < 300) begin
        @(negedge ap_clk);
        if (arvalid) arv_cycles++;
        n++;
      end
      if (sb.size() != 0) begin
        checks++; errors++;
        $display("FAIL cmd_timeout: got no done after %0d cycles expected done for op %0d", n, op);
        sb.delete();
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned arv, n;
    int          op, rerr;
    bit          fast;
    int unsigned d0, d1, d2, d3, d4;
    logic [1:0]  br;

    ap_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    k_aw_dly = 0; k_w_dly = 0; k_b_dly = 0; k_ar_dly = 0; k_r_dly = 0;
    k_ar_hang = 0; k_bresp = 2'b00; k_rerr_word = -1;
    wr_count = 0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    set_counters('0, '0, '0);

    repeat (3) @(negedge ap_clk);
    check("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    check("valids_after_reset", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("done_after_reset", 64'({done, err}), 64'd0);
    check("addr_data_after_reset", {awaddr, araddr, wdata}, 64'd0);

    // START with an always-ready slave
    issue(1, 0, 0, 0, 0, 0, 0, 2'b00, -1, 3, 1, arv);
    // Snapshot after 7 stream beats
    set_counters(64'd7, 64'd41, 64'd3);
    issue(3, 0, 0, 0, 0, 0, 0, 2'b00, -1, 13, 1, arv);
    // AW ready 3 cycles before W
    issue(0, 0, 3, 0, 0, 0, 0, 2'b00, -1, 6, 1, arv);
    // CLEAR answered with SLVERR, then a clean START
    issue(2, 0, 0, 0, 0, 0, 0, 2'b10, -1, 3, 1, arv);
    issue(1, 0, 0, 0, 0, 0, 0, 2'b00, -1, 3, 1, arv);
    // arready held low: abort after TO wait cycles, snapshot outputs kept
    set_counters({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    issue(3, 0, 0, 0, 0, 0, 1, 2'b00, -1, TO + 2, 1, arv);
    check("arvalid_wait_cycles", 64'(arv), 64'(TO));

    for (int i = 0; i < 40; i++) begin
      op   = int'($urandom_range(0, 3));
      fast = 1'($urandom_range(0, 1));
      d0 = fast ? 0 : $urandom_range(0, 3);
      d1 = fast ? 0 : $urandom_range(0, 3);
      d2 = fast ? 0 : $urandom_range(0, 3);
      d3 = fast ? 0 : $urandom_range(0, 3);
      d4 = fast ? 0 : $urandom_range(0, 3);
      br   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rerr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      if (op == 3) set_counters({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      issue(op, d0, d1, d2, d3, d4, 0, br, rerr, fast ? ((op == 3) ? 13 : 3) : 0, 1, arv);
    end

    // Reset while waiting on the data of word 3
    set_counters({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    issue(3, 0, 0, 0, 0, 3, 0, 2'b00, -1, 0, 0, arv);
    n = 0;
    while (!(rd_count == 3 && rready) && n < 200) begin @(negedge ap_clk); n++; end
    check("reached_rd_data_word3", 64'(rd_count == 3 && rready), 64'd1);
    sb.delete();
    @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(negedge ap_clk);
    check("cmd_ready_mid_reset", 64'(cmd_ready), 64'd0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("valids_after_abort", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("done_after_abort", 64'(done), 64'd0);
    check("snap_after_abort", snap_assertions | snap_cycles | snap_latency, 64'd0);
    check("cmd_ready_after_abort", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge ap_clk);
    issue(1, 0, 0, 0, 0, 0, 0, 2'b00, -1, 3, 1, arv);
    set_counters({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    issue(3, 0, 0, 0, 0, 0, 0, 2'b00, -1, 13, 1, arv);

    repeat (3) @(negedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
